dmi_host_ctrl: RTL and testbench

DTM-side initiator for the Debug Module Interface. Converts single-cycle update strobes from the JTAG DTM `dmi` shift register into `dm::dmi_req_t` requests and collects `dm::dmi_resp_t` responses. It maintains the sticky `dmistat` error and the capture value shifted back out to the debugger. It sits between the TAP controller and the DM's DMI request/response ports, on the DM clock domain.

---
 rtl/dmi_host_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dmi_host_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_host_ctrl.sv
// dmi_host_ctrl: DTM-side initiator for the Debug Module Interface.
// Turns one-cycle update strobes from the DTM dmi shift register into DMI
// requests, collects the responses, and keeps the sticky dmistat error plus
// the capture value shifted back to the debugger.
// Optional feature macro: DMI_TIMEOUT_EN enables a response timeout of
// TimeoutCycles clk_i cycles while waiting for a response.
module dmi_host_ctrl #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        upd_valid_i,
  input  logic [6:0]  upd_addr_i,
  input  logic [1:0]  upd_op_i,
  input  logic [31:0] upd_data_i,
  input  logic        dmi_clear_i,
  input  logic        dmi_hard_reset_i,
  output logic [6:0]  cap_addr_o,
  output logic [31:0] cap_data_o,
  output logic [1:0]  cap_op_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  localparam logic [1:0] OpNop      = 2'd0;
  localparam logic [1:0] OpRead     = 2'd1;
  localparam logic [1:0] OpWrite    = 2'd2;
  localparam logic [1:0] DtmSuccess = 2'd0;
  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrFailed  = 2'd2;
  localparam logic [1:0] ErrBusy    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  state_e      state_r, state_s;
  logic [1:0]  err_r, err_s;
  logic [6:0]  req_addr_r, req_addr_s;
  logic [1:0]  req_op_r, req_op_s;
  logic [31:0] req_data_r, req_data_s;
  logic [6:0]  cap_addr_r, cap_addr_s;
  logic [31:0] cap_data_r, cap_data_s;

  logic [31:0] resp_data_s;
  logic [1:0]  resp_code_s;
  logic        upd_is_access_s;

  assign resp_data_s     = dmi_resp_i[33:2];
  assign resp_code_s     = dmi_resp_i[1:0];
  assign upd_is_access_s = (upd_op_i == OpRead) || (upd_op_i == OpWrite);

`ifdef DMI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_r, cnt_s;
  logic            timeout_s;

  // Last counted cycle of the response window; IDLE follows the next edge.
  assign timeout_s = (cnt_r == CntW'(TimeoutCycles - 1));
`endif

  // Next-state, request latch, capture registers and sticky error update.
  always_comb begin
    state_s    = state_r;
    err_s      = err_r;
    req_addr_s = req_addr_r;
    req_op_s   = req_op_r;
    req_data_s = req_data_r;
    cap_addr_s = cap_addr_r;
    cap_data_s = cap_data_r;
`ifdef DMI_TIMEOUT_EN
    cnt_s      = cnt_r;
`endif

    if (dmi_hard_reset_i) begin
      // Abandon whatever is in flight; capture registers keep their values.
      state_s = ST_IDLE;
      err_s   = ErrNone;
    end else begin
      // dmireset acts before the same-cycle update is judged.
      if (dmi_clear_i) begin
        err_s = ErrNone;
      end else begin
        err_s = err_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (upd_valid_i && (err_s == ErrNone) && upd_is_access_s) begin
            req_addr_s = upd_addr_i;
            req_op_s   = upd_op_i;
            req_data_s = upd_data_i;
            cap_addr_s = upd_addr_i;
            state_s    = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dmi_req_ready_i) begin
            state_s = ST_WAIT_RESP;
`ifdef DMI_TIMEOUT_EN
            cnt_s   = '0;
`endif
          end else begin
            state_s = ST_REQ;
          end
          if (upd_valid_i) begin
            err_s = ErrBusy;
          end else begin
            err_s = err_s;
          end
        end
        ST_WAIT_RESP: begin
          if (dmi_resp_valid_i) begin
            cap_data_s = resp_data_s;
            state_s    = ST_IDLE;
            if ((resp_code_s != DtmSuccess) && (err_s == ErrNone)) begin
              err_s = ErrFailed;
            end else begin
              err_s = err_s;
            end
`ifdef DMI_TIMEOUT_EN
          end else if (timeout_s) begin
            state_s = ST_IDLE;
            if (err_s == ErrNone) begin
              err_s = ErrFailed;
            end else begin
              err_s = err_s;
            end
          end else begin
            cnt_s   = cnt_r + CntW'(1);
            state_s = ST_WAIT_RESP;
`else
          end else begin
            state_s = ST_WAIT_RESP;
`endif
          end
          // A collision always wins over a failed response in the same cycle.
          if (upd_valid_i) begin
            err_s = ErrBusy;
          end else begin
            err_s = err_s;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      err_r      <= ErrNone;
      req_addr_r <= 7'd0;
      req_op_r   <= OpNop;
      req_data_r <= 32'd0;
      cap_addr_r <= 7'd0;
      cap_data_r <= 32'd0;
`ifdef DMI_TIMEOUT_EN
      cnt_r      <= '0;
`endif
    end else begin
      state_r    <= state_s;
      err_r      <= err_s;
      req_addr_r <= req_addr_s;
      req_op_r   <= req_op_s;
      req_data_r <= req_data_s;
      cap_addr_r <= cap_addr_s;
      cap_data_r <= cap_data_s;
`ifdef DMI_TIMEOUT_EN
      cnt_r      <= cnt_s;
`endif
    end
  end

  // Status seen by the debugger: sticky error first, then busy, else success.
  always_comb begin
    if (err_r != ErrNone) begin
      cap_op_o = err_r;
    end else if (state_r != ST_IDLE) begin
      cap_op_o = ErrBusy;
    end else begin
      cap_op_o = 2'd0;
    end
  end

  assign dmi_req_valid_o  = (state_r == ST_REQ);
  assign dmi_req_o        = {req_addr_r, req_op_r, req_data_r};
  assign dmi_resp_ready_o = 1'b1;
  assign cap_addr_o       = cap_addr_r;
  assign cap_data_o       = cap_data_r;

endmodule

// File: tb/tb_dmi_host_ctrl.sv
// Directed self-checking bench for dmi_host_ctrl.
module tb_dmi_host_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        upd_valid_i;
  logic [6:0]  upd_addr_i;
  logic [1:0]  upd_op_i;
  logic [31:0] upd_data_i;
  logic        dmi_clear_i;
  logic        dmi_hard_reset_i;
  logic [6:0]  cap_addr_o;
  logic [31:0] cap_data_o;
  logic [1:0]  cap_op_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [33:0] dmi_resp_i;

  int checks = 0;
  int errors = 0;

  dmi_host_ctrl #(.TimeoutCycles(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .upd_valid_i      (upd_valid_i),
    .upd_addr_i       (upd_addr_i),
    .upd_op_i         (upd_op_i),
    .upd_data_i       (upd_data_i),
    .dmi_clear_i      (dmi_clear_i),
    .dmi_hard_reset_i (dmi_hard_reset_i),
    .cap_addr_o       (cap_addr_o),
    .cap_data_o       (cap_data_o),
    .cap_op_o         (cap_op_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    upd_valid_i = 1'b1;
    upd_addr_i  = a;
    upd_op_i    = op;
    upd_data_i  = d;
  endtask

  task automatic idle_inputs();
    upd_valid_i      = 1'b0;
    dmi_clear_i      = 1'b0;
    dmi_hard_reset_i = 1'b0;
    dmi_resp_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    upd_addr_i = 7'd0; upd_op_i = 2'd0; upd_data_i = 32'd0;
    dmi_req_ready_i = 1'b1;
    dmi_resp_i = 34'd0;
    tick(); tick();
    chk("rst_valid", dmi_req_valid_o, 1'b0);
    chk("rst_req", dmi_req_o, 41'd0);
    chk("rst_cap_addr", cap_addr_o, 7'd0);
    chk("rst_cap_data", cap_data_o, 32'd0);
    chk("rst_cap_op", cap_op_o, 2'd0);
    chk("resp_ready", dmi_resp_ready_o, 1'b1);
    rst_ni = 1'b1;
    tick();

    // Write, success
    upd(7'h10, 2'd2, 32'h0000_0001);
    tick();
    upd_valid_i = 1'b0;
    chk("wr_valid", dmi_req_valid_o, 1'b1);
    chk("wr_req", dmi_req_o, {7'h10, 2'd2, 32'h0000_0001});
    chk("wr_busy_req", cap_op_o, 2'd3);
    chk("wr_cap_addr", cap_addr_o, 7'h10);
    tick();
    chk("wr_valid_drop", dmi_req_valid_o, 1'b0);
    chk("wr_busy_wait", cap_op_o, 2'd3);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("wr_done", cap_op_o, 2'd0);

    // Read, data return
    upd(7'h11, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    chk("rd_req", dmi_req_o, {7'h11, 2'd1, 32'h0});
    tick();
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0040_0C82, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("rd_data", cap_data_o, 32'h0040_0C82);
    chk("rd_op", cap_op_o, 2'd0);

    // Busy collision, then clear
    upd(7'h05, 2'd2, 32'h0000_00AA);
    tick(); tick();
    upd(7'h06, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    chk("col_op", cap_op_o, 2'd3);
    chk("col_no_req", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_1234, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("col_sticky", cap_op_o, 2'd3);
    chk("col_data", cap_data_o, 32'h0000_1234);
    chk("col_addr", cap_addr_o, 7'h05);
    upd(7'h07, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    chk("third_no_req", dmi_req_valid_o, 1'b0);
    chk("third_addr", cap_addr_o, 7'h05);
    dmi_clear_i = 1'b1;
    tick();
    dmi_clear_i = 1'b0;
    chk("clr_op", cap_op_o, 2'd0);
    upd(7'h04, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    chk("clr_req_valid", dmi_req_valid_o, 1'b1);
    chk("clr_req", dmi_req_o, {7'h04, 2'd1, 32'h0});
    chk("clr_addr", cap_addr_o, 7'h04);
    tick();

    // Failed response, sticky through NOP and ignored access
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_DEAD, 2'd2};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("fail_op", cap_op_o, 2'd2);
    chk("fail_data", cap_data_o, 32'h0000_DEAD);
    upd(7'h01, 2'd0, 32'h0);
    tick();
    chk("fail_nop", cap_op_o, 2'd2);
    upd(7'h02, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    chk("fail_ignored", dmi_req_valid_o, 1'b0);
    chk("fail_ign_op", cap_op_o, 2'd2);
    dmi_clear_i = 1'b1;
    tick();
    dmi_clear_i = 1'b0;
    chk("fail_clr", cap_op_o, 2'd0);

    // Hard reset in REQ with ready low; clear plus busy update first
    dmi_req_ready_i = 1'b0;
    upd(7'h20, 2'd1, 32'h0);
    tick();
    chk("hr_valid", dmi_req_valid_o, 1'b1);
    dmi_clear_i = 1'b1;
    tick();
    upd_valid_i = 1'b0; dmi_clear_i = 1'b0;
    chk("clr_busy_err", cap_op_o, 2'd3);
    chk("req_stable", dmi_req_o, {7'h20, 2'd1, 32'h0});
    dmi_hard_reset_i = 1'b1;
    tick();
    dmi_hard_reset_i = 1'b0;
    chk("hr_drop", dmi_req_valid_o, 1'b0);
    chk("hr_op", cap_op_o, 2'd0);
    chk("hr_addr", cap_addr_o, 7'h20);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_BEEF, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("hr_late_data", cap_data_o, 32'h0000_DEAD);
    chk("hr_late_op", cap_op_o, 2'd0);

    // Reset mid-transaction
    upd(7'h30, 2'd2, 32'h5);
    tick();
    upd_valid_i = 1'b0;
    chk("rm_valid", dmi_req_valid_o, 1'b1);
    rst_ni = 1'b0;
    tick();
    chk("rm_valid0", dmi_req_valid_o, 1'b0);
    chk("rm_req0", dmi_req_o, 41'd0);
    chk("rm_addr0", cap_addr_o, 7'd0);
    chk("rm_data0", cap_data_o, 32'd0);
    chk("rm_op0", cap_op_o, 2'd0);
    rst_ni = 1'b1;
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_BEEF, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("rm_late_data", cap_data_o, 32'd0);
    dmi_req_ready_i = 1'b1;

    // Update in the same cycle as the response sees busy
    upd(7'h12, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    tick();
    upd(7'h13, 2'd1, 32'h0);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_0077, 2'd0};
    tick();
    upd_valid_i = 1'b0; dmi_resp_valid_i = 1'b0;
    chk("same_cyc_op", cap_op_o, 2'd3);
    chk("same_cyc_addr", cap_addr_o, 7'h12);
    dmi_clear_i = 1'b1;
    tick();
    dmi_clear_i = 1'b0;

`ifdef DMI_TIMEOUT_EN
    // Timeout with TimeoutCycles = 8
    upd(7'h15, 2'd1, 32'h0);
    tick();
    upd_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_still_busy", cap_op_o, 2'd3);
    tick();
    chk("to_op", cap_op_o, 2'd2);
    chk("to_data", cap_data_o, 32'h0000_0077);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h0000_5555, 2'd0};
    tick();
    dmi_resp_valid_i = 1'b0;
    chk("to_late_data", cap_data_o, 32'h0000_0077);
    chk("to_late_op", cap_op_o, 2'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
